// File: rtl/in_capture_unit_if.sv
// Bus between the IN-capture unit and its surroundings: controller request,
// board button/switches, and the captured word with its handshake/status bits.
interface in_capture_unit_if #(
  parameter int SW_WIDTH = 16
);
  logic                in_req;
  logic                button_in;
  logic [SW_WIDTH-1:0] switches;
  logic [31:0]         in_data;
  logic                in_valid;
  logic                stall;
  logic                waiting;
  logic                btn_level;

  modport master (
    output in_req, button_in, switches,
    input  in_data, in_valid, stall, waiting, btn_level
  );

  modport slave (
    input  in_req, button_in, switches,
    output in_data, in_valid, stall, waiting, btn_level
  );
endinterface

// File: rtl/in_capture_unit.sv
// Synchronises and debounces the confirm button, stalls the core during an IN
// instruction and captures the extended switch word on a clean press.
module in_capture_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_WIDTH        = 16,
  parameter bit SIGN_EXT        = 1'b1
) (
  input logic               clock,
  input logic               rst,
  in_capture_unit_if.slave  bus
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    CAPTURE
  } state_t;

  state_t        state, next_state;
  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          level;
  logic          valid_q;
  logic [31:0]   data_q;
  logic [31:0]   ext_word;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.button_in;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    ext_word               = '0;
    ext_word[SW_WIDTH-1:0] = bus.switches;
    for (int unsigned i = SW_WIDTH; i < 32; i++) begin
      ext_word[i] = SIGN_EXT & bus.switches[SW_WIDTH-1];
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.in_req) next_state = level ? WAIT_RELEASE : WAIT_PRESS;
      end
      WAIT_RELEASE: begin
        if (!level) next_state = bus.in_req ? WAIT_PRESS : IDLE;
      end
      WAIT_PRESS: begin
        // Withdrawal takes priority over a simultaneous press.
        if (!bus.in_req)  next_state = IDLE;
        else if (level)   next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = WAIT_RELEASE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= next_state;
      valid_q <= (next_state == CAPTURE);
      if (next_state == CAPTURE) data_q <= ext_word;
    end
  end

  assign bus.in_data   = data_q;
  assign bus.in_valid  = valid_q;
  assign bus.stall     = rst & bus.in_req & (state != CAPTURE);
  assign bus.waiting   = rst & (state == WAIT_PRESS);
  assign bus.btn_level = level;
endmodule

// File: tb/tb_in_capture_unit.sv
// Directed bench for in_capture_unit: two instances (sign- and zero-extending)
// share one stimulus stream with DEBOUNCE_CYCLES=4.
module tb_in_capture_unit;
  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        in_req;
  logic        button_in;
  logic [15:0] switches;

  int checks   = 0;
  int failures = 0;
  int pulses1  = 0;
  int pulses0  = 0;
  bit ok;

  in_capture_unit_if #(.SW_WIDTH(16)) if1 ();
  in_capture_unit_if #(.SW_WIDTH(16)) if0 ();

  assign if1.in_req    = in_req;
  assign if1.button_in = button_in;
  assign if1.switches  = switches;
  assign if0.in_req    = in_req;
  assign if0.button_in = button_in;
  assign if0.switches  = switches;

  in_capture_unit #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(16), .SIGN_EXT(1'b1)) dut_sext (
    .clock (clock),
    .rst   (rst),
    .bus   (if1)
  );

  in_capture_unit #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(16), .SIGN_EXT(1'b0)) dut_zext (
    .clock (clock),
    .rst   (rst),
    .bus   (if0)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (if1.in_valid) pulses1++;
    if (if0.in_valid) pulses0++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (if1.in_valid) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    in_req    = 1'b1;
    button_in = 1'b0;
    switches  = 16'h0;
    for (int i = 0; i < 5; i++) begin
      button_in = 1'($urandom);
      switches  = 16'($urandom);
      step(1);
    end
    check("rst_stall",   32'(if1.stall),     32'd0);
    check("rst_waiting", 32'(if1.waiting),   32'd0);
    check("rst_valid",   32'(if1.in_valid),  32'd0);
    check("rst_data",    if1.in_data,        32'd0);
    check("rst_level",   32'(if1.btn_level), 32'd0);
    in_req    = 1'b0;
    button_in = 1'b0;
    switches  = 16'h0;
    step(1);
    rst = 1'b1;
    step(8);
    check("idle_data",    if1.in_data,       32'd0);
    check("idle_data0",   if0.in_data,       32'd0);
    check("idle_valid",   32'(if1.in_valid), 32'd0);
    check("idle_stall",   32'(if1.stall),    32'd0);
    check("idle_waiting", 32'(if1.waiting),  32'd0);
    check("idle_level",   32'(if1.btn_level), 32'd0);

    // Basic capture: request at cycle 0, press at cycle 10 for 20 cycles
    in_req   = 1'b1;
    switches = 16'hFFFE;
    #1;
    check("b_stall_c0", 32'(if1.stall), 32'd1);
    step(1);
    check("b_waiting_c1", 32'(if1.waiting), 32'd1);
    step(9);
    button_in = 1'b1;
    step(5);
    check("b_level_c15", 32'(if1.btn_level), 32'd0);
    step(1);
    check("b_level_c16", 32'(if1.btn_level), 32'd1);
    check("b_valid_c16", 32'(if1.in_valid),  32'd0);
    check("b_stall_c16", 32'(if1.stall),     32'd1);
    step(1);
    check("b_valid_c17",  32'(if1.in_valid), 32'd1);
    check("b_valid0_c17", 32'(if0.in_valid), 32'd1);
    check("b_data_sext",  if1.in_data, 32'hFFFFFFFE);
    check("b_data_zext",  if0.in_data, 32'h0000FFFE);
    check("b_stall_c17",  32'(if1.stall), 32'd0);
    step(1);
    check("b_valid_c18",   32'(if1.in_valid), 32'd0);
    check("b_stall_c18",   32'(if1.stall),    32'd1);
    check("b_waiting_c18", 32'(if1.waiting),  32'd0);
    in_req = 1'b0;
    step(12);
    button_in = 1'b0;
    step(10);
    check("b_pulses1", 32'(pulses1), 32'd1);
    check("b_pulses0", 32'(pulses0), 32'd1);
    check("b_hold",    if1.in_data,  32'hFFFFFFFE);

    // Second capture with switches 8001
    in_req   = 1'b1;
    switches = 16'h8001;
    step(10);
    button_in = 1'b1;
    step(7);
    check("c_valid",     32'(if1.in_valid), 32'd1);
    check("c_data_zext", if0.in_data, 32'h00008001);
    check("c_data_sext", if1.in_data, 32'hFFFF8001);
    in_req = 1'b0;
    step(1);
    check("c_hold", if0.in_data, 32'h00008001);
    step(12);
    button_in = 1'b0;
    step(10);

    // Short glitches during WAIT_PRESS
    in_req = 1'b1;
    step(2);
    for (int i = 0; i < 6; i++) begin
      button_in = 1'b1;
      step(3);
      button_in = 1'b0;
      step(1);
      check("d_level", 32'(if1.btn_level), 32'd0);
      check("d_stall", 32'(if1.stall),     32'd1);
    end
    step(6);
    check("d_level_end",   32'(if1.btn_level), 32'd0);
    check("d_waiting_end", 32'(if1.waiting),   32'd1);
    check("d_pulses",      32'(pulses1),       32'd2);

    // Withdrawal on the same cycle the debounced level rises
    button_in = 1'b1;
    step(6);
    check("e_level", 32'(if1.btn_level), 32'd1);
    in_req = 1'b0;
    step(1);
    check("e_valid",   32'(if1.in_valid), 32'd0);
    check("e_waiting", 32'(if1.waiting),  32'd0);
    check("e_stall",   32'(if1.stall),    32'd0);
    button_in = 1'b0;
    step(10);
    check("e_pulses", 32'(pulses1), 32'd2);

    // Button already held when the request arrives
    button_in = 1'b1;
    step(10);
    in_req = 1'b1;
    step(1);
    check("f_waiting_held", 32'(if1.waiting), 32'd0);
    check("f_stall_held",   32'(if1.stall),   32'd1);
    step(10);
    check("f_no_capture", 32'(pulses1), 32'd2);
    button_in = 1'b0;
    step(7);
    check("f_waiting_rel", 32'(if1.waiting), 32'd1);
    button_in = 1'b1;
    wait_valid(20, ok);
    check("f_valid_seen", 32'(ok), 32'd1);
    check("f_data", if1.in_data, 32'hFFFF8001);
    step(1);
    check("f_pulses", 32'(pulses1), 32'd3);

    // Back-to-back: request stays high, long press yields one pulse only
    step(30);
    check("g_waiting_hold", 32'(if1.waiting), 32'd0);
    check("g_stall_hold",   32'(if1.stall),   32'd1);
    check("g_one_pulse",    32'(pulses1),     32'd3);
    button_in = 1'b0;
    switches  = 16'h1234;
    step(8);
    check("g_waiting_rel", 32'(if1.waiting), 32'd1);
    button_in = 1'b1;
    wait_valid(20, ok);
    check("g_valid_seen", 32'(ok), 32'd1);
    check("g_data", if1.in_data, 32'h00001234);
    step(1);
    check("g_pulses", 32'(pulses1), 32'd4);
    button_in = 1'b0;
    in_req    = 1'b0;
    step(10);

    // Reset during WAIT_PRESS
    in_req = 1'b1;
    step(2);
    check("h_waiting_pre", 32'(if1.waiting), 32'd1);
    rst = 1'b0;
    #1;
    check("h_rst_stall",   32'(if1.stall),    32'd0);
    check("h_rst_waiting", 32'(if1.waiting),  32'd0);
    check("h_rst_data",    if1.in_data,       32'd0);
    step(2);
    rst = 1'b1;
    step(20);
    check("h_pulses",  32'(pulses1),       32'd4);
    check("h_valid",   32'(if1.in_valid),  32'd0);
    check("h_data",    if1.in_data,        32'd0);
    check("h_waiting", 32'(if1.waiting),   32'd1);
    in_req = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/in_capture_unit.md
Name: in_capture_unit

Overview:
- Sits directly upstream of the instruction-decode and immediate path. It supplies the 16-bit switch word that the IN instruction consumes.
- Synchronises and debounces the raw confirm button, and stalls the core while an IN instruction waits for the operator.
- On a clean button press it latches the switches, extends them to 32 bits and releases the core with a one-cycle valid pulse.
- Replaces the ad-hoc pairing of the debouncer and the button-state block with one clocked, handshaked unit.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised button sample must differ from the stable level before the level flips. Legal range 2..65535.
- SW_WIDTH, 16: width of the switch bus.
- SIGN_EXT, 1: 1 sign-extends the switch word to 32 bits; 0 zero-extends it.

Ports:
- clock, input, 1: single system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_req, input, 1: level from the controller; high while the current instruction is IN.
- button_in, input, 1: raw, asynchronous board button, active-high.
- switches, input, SW_WIDTH: raw board switches. Sampled only at capture and assumed stable while the button is pressed.
- in_data, output, 32: captured, extended switch word.
- in_valid, output, 1: one-cycle pulse; in_data is new and the IN instruction may complete.
- stall, output, 1: freezes the PC and register write while high.
- waiting, output, 1: LED indicator; the unit is waiting for a press.
- btn_level, output, 1: debounced button level, for observation.

Behaviour:
- Reset (rst low, asynchronous):
  - state returns to IDLE.
  - Both sync flops, the debounce counter, btn_level, in_data and in_valid clear to 0.
  - stall and waiting read 0 while rst is low.
  - Reset mid-wait abandons the request; no capture pulse is emitted afterwards unless a new press occurs.
- Synchroniser:
  - Two flops on button_in, giving btn_sync with a 2-cycle latency.
- Debounce:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)) + 1 bits.
  - If btn_sync == btn_level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_level toggles and the counter clears on the same edge.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
  - Total press-to-btn_level latency is 2 + DEBOUNCE_CYCLES cycles.
- FSM, registered state, 4 states:
  - IDLE: when in_req is high, go to WAIT_RELEASE if btn_level = 1, else go to WAIT_PRESS. A button already held at request time is never accepted as a press.
  - WAIT_RELEASE: when btn_level = 0, go to WAIT_PRESS if in_req is high, else go to IDLE.
  - WAIT_PRESS: if in_req = 0 (request withdrawn), go to IDLE with no capture. Else, when btn_level = 1, go to CAPTURE; on the same edge in_data <= extend(switches).
  - CAPTURE: in_valid = 1 for exactly this cycle, then always go to WAIT_RELEASE. One press therefore yields exactly one capture.
- Combinational outputs:
  - stall = in_req AND (state != CAPTURE).
  - waiting = (state == WAIT_PRESS).
- in_valid is registered as (next_state == CAPTURE). in_valid and the CAPTURE state coincide.
- in_data holds its value until the next capture and is never cleared except by reset.
- Extension:
  - SIGN_EXT = 1: in_data = {{(32-SW_WIDTH){switches[SW_WIDTH-1]}}, switches}.
  - SIGN_EXT = 0: the upper bits are 0.
- Back-to-back IN instructions (in_req stays high through CAPTURE): the next request passes through WAIT_RELEASE and needs a fresh press.
- Simultaneous in_req fall and btn_level rise in WAIT_PRESS: the withdrawal wins, so the state goes to IDLE with no in_valid.
- Minimum request-to-valid latency from IDLE with the button released: 1 cycle (IDLE to WAIT_PRESS) + press latency + 1 cycle.

Test Plan:
- DEBOUNCE_CYCLES=4, SIGN_EXT=1. Assert rst low with random inputs, then release it. Required: in_data=0, in_valid=0, stall=0, waiting=0, btn_level=0 until stimulus.
- in_req=1, switches=16'hFFFE. Press the button at cycle 10 and hold it for 20 cycles. Required: stall=1 from in_req rise; waiting=1 from cycle 1; btn_level=1 at cycle 16; in_valid pulses once at cycle 17 with in_data=32'hFFFFFFFE; stall=0 in that cycle only.
- SIGN_EXT=0, switches=16'h8001, same press. Required: in_data=32'h00008001.
- Button pulses of 3 cycles high, 1 low, repeated during WAIT_PRESS. Required: btn_level stays 0, no in_valid, stall stays 1.
- Button held before in_req rises. Required: WAIT_RELEASE entered and no capture until release; after release plus a new press, exactly one in_valid.
- in_req held high over two consecutive captures with a single long press. Required: one in_valid only; a second press is needed for the second pulse. Also, rst pulsed low during WAIT_PRESS: required state IDLE, no in_valid, in_data keeps 0 after reset.
